wb_select_stage: RTL

- Parametrised writeback stage that replaces the fixed 2:1, 32-bit writeback select.
- Selects one of NSRC result sources (ALU, load data, PC+4, immediate, ...) and registers the result in a MEM/WB-style register.
- A one-entry skid buffer lets the upstream ready be registered. The stage drives the register-file write port and a last-write bypass for operand forwarding.

---
 rtl/wb_pkg.sv | 19 +
 rtl/wb_select_stage_if.sv | 36 +++
 rtl/wb_mux_n.sv | 25 ++
 rtl/wb_select_stage.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared writeback definitions: source indices and write-enable qualification.
// Imported by the writeback select stage, its sub-blocks and benches.
package wb_pkg;

  localparam int WB_SRC_ALU = 0;
  localparam int WB_SRC_MEM = 1;
  localparam int WB_SRC_PC4 = 2;
  localparam int WB_SRC_IMM = 3;

  function automatic logic wb_eff_we(
    input logic we,
    input logic rd_zero,
    input logic sel_oor,
    input logic zero_reg
  );
    return we && !(zero_reg && rd_zero) && !sel_oor;
  endfunction

endpackage

// File: rtl/wb_select_stage_if.sv
// Upstream result handshake into the writeback select stage.
// Master is the producer, slave is the stage.
interface wb_select_stage_if #(
  parameter int DATA_W = 32,
  parameter int NSRC   = 4,
  parameter int REG_AW = 5
);

  localparam int SEL_W = $clog2(NSRC);

  logic                   in_valid;
  logic                   in_ready;
  logic [NSRC*DATA_W-1:0] in_src;
  logic [SEL_W-1:0]       in_sel;
  logic [REG_AW-1:0]      in_rd;
  logic                   in_we;

  modport master (
    output in_valid,
    output in_src,
    output in_sel,
    output in_rd,
    output in_we,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_src,
    input  in_sel,
    input  in_rd,
    input  in_we,
    output in_ready
  );

endinterface

// File: rtl/wb_mux_n.sv
// NSRC:1 result select over a flattened source bus.
// Flags selects that name no existing source.
module wb_mux_n #(
  parameter  int DATA_W = 32,
  parameter  int NSRC   = 4,
  localparam int SEL_W  = $clog2(NSRC)
) (
  input  logic [NSRC*DATA_W-1:0] src_i,
  input  logic [SEL_W-1:0]       sel_i,
  output logic [DATA_W-1:0]      data_o,
  output logic                   oor_o
);

  always_comb begin
    data_o = '0;
    oor_o  = 1'b1;
    for (int k = 0; k < NSRC; k++) begin
      if (sel_i == SEL_W'(k)) begin
        data_o = src_i[k*DATA_W +: DATA_W];
        oor_o  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/wb_select_stage.sv
// Writeback select: N-way result mux, main + skid register,
// register-file write port and last-write bypass.
module wb_select_stage
  import wb_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NSRC     = 4,
  parameter int REG_AW   = 5,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  wb_select_stage_if.slave    in_if,
  input  logic                flush,
  input  logic                rf_stall,
  output logic                rf_we,
  output logic [REG_AW-1:0]   rf_waddr,
  output logic [DATA_W-1:0]   rf_wdata,
  output logic                byp_valid,
  output logic [REG_AW-1:0]   byp_addr,
  output logic [DATA_W-1:0]   byp_data,
  output logic                sel_err
);

  logic [DATA_W-1:0] mux_data;
  logic              mux_oor;
  logic              in_we_eff;
  logic              accept;
  logic              drain;

  logic              m_valid_q, m_valid_d;
  logic              m_we_q, m_we_d;
  logic [REG_AW-1:0] m_rd_q, m_rd_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;

  logic              s_valid_q, s_valid_d;
  logic              s_we_q, s_we_d;
  logic [REG_AW-1:0] s_rd_q, s_rd_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;

  logic              byp_valid_q;
  logic [REG_AW-1:0] byp_addr_q;
  logic [DATA_W-1:0] byp_data_q;
  logic              sel_err_q;

  wb_mux_n #(
    .DATA_W (DATA_W),
    .NSRC   (NSRC)
  ) u_mux (
    .src_i  (in_if.in_src),
    .sel_i  (in_if.in_sel),
    .data_o (mux_data),
    .oor_o  (mux_oor)
  );

  assign in_we_eff = wb_eff_we(in_if.in_we,
                               in_if.in_rd == '0,
                               mux_oor,
                               ZERO_REG);

  // Ready depends only on the skid slot, so it is a pure flop output.
  assign in_if.in_ready = !s_valid_q;

  assign accept = in_if.in_valid && !s_valid_q && !flush;
  assign drain  = m_valid_q && !rf_stall && !flush;

  always_comb begin
    m_valid_d = m_valid_q;
    m_we_d    = m_we_q;
    m_rd_d    = m_rd_q;
    m_data_d  = m_data_q;
    s_valid_d = s_valid_q;
    s_we_d    = s_we_q;
    s_rd_d    = s_rd_q;
    s_data_d  = s_data_q;
    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else begin
      if (drain) begin
        m_valid_d = s_valid_q;
        m_we_d    = s_we_q;
        m_rd_d    = s_rd_q;
        m_data_d  = s_data_q;
        s_valid_d = 1'b0;
      end
      if (accept) begin
        if (!m_valid_q || drain) begin
          m_valid_d = 1'b1;
          m_we_d    = in_we_eff;
          m_rd_d    = in_if.in_rd;
          m_data_d  = mux_data;
        end else begin
          s_valid_d = 1'b1;
          s_we_d    = in_we_eff;
          s_rd_d    = in_if.in_rd;
          s_data_d  = mux_data;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      m_we_q    <= 1'b0;
      m_rd_q    <= '0;
      m_data_q  <= '0;
      s_valid_q <= 1'b0;
      s_we_q    <= 1'b0;
      s_rd_q    <= '0;
      s_data_q  <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_we_q    <= m_we_d;
      m_rd_q    <= m_rd_d;
      m_data_q  <= m_data_d;
      s_valid_q <= s_valid_d;
      s_we_q    <= s_we_d;
      s_rd_q    <= s_rd_d;
      s_data_q  <= s_data_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byp_valid_q <= 1'b0;
      byp_addr_q  <= '0;
      byp_data_q  <= '0;
      sel_err_q   <= 1'b0;
    end else begin
      if (rf_we) begin
        byp_valid_q <= 1'b1;
        byp_addr_q  <= m_rd_q;
        byp_data_q  <= m_data_q;
      end
      sel_err_q <= accept && mux_oor;
    end
  end

  assign rf_we     = drain && m_we_q;
  assign rf_waddr  = m_rd_q;
  assign rf_wdata  = m_data_q;
  assign byp_valid = byp_valid_q;
  assign byp_addr  = byp_addr_q;
  assign byp_data  = byp_data_q;
  assign sel_err   = sel_err_q;

  a_no_skid_overrun: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(accept && drain && s_valid_q)
  );

endmodule
